// File: rtl/arb_req_queue.sv
// Requester-side endpoint of the round-robin arbiter. It buffers outgoing
// transactions in a small FIFO, drives this requester's req_bitmap bit and
// pops the head on grant & accept. It also flags starvation and overflow.
module arb_req_queue #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned STARVE_LIMIT = 15
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       enq_en,
   input  logic [DATA_WIDTH-1:0]      enq_data,
   output logic                       full,
   output logic                       almost_full,
   output logic                       arb_req,
   input  logic                       arb_grant,
   input  logic                       arb_accept,
   output logic [DATA_WIDTH-1:0]      deq_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       starve,
   output logic                       ovf_err
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

   logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
   logic [PW-1:0]                    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]                    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]                    count_q, count_d;
   logic [SW-1:0]                    wait_q, wait_d;
   logic                             ovf_q, ovf_d;
   logic                             push, pop;

   // Status is derived only from registered state; a push never passes
   // through to the head in the same cycle.
   assign full        = (count_q == CW'(DEPTH));
   assign almost_full = (count_q >= CW'(DEPTH - 1));
   assign arb_req     = (count_q != '0);
   assign deq_data    = mem_q[rd_ptr_q];
   assign count       = count_q;
   assign starve      = (wait_q == SW'(STARVE_LIMIT));
   assign ovf_err     = ovf_q;

   assign push = enq_en & ~full;
   assign pop  = arb_grant & arb_accept & arb_req;

   // Next-state for pointers, occupancy, wait counter and sticky overflow.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      wait_d   = wait_q;
      ovf_d    = ovf_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      // Waiting counts only cycles where a request is up and not served.
      if (pop || !arb_req)
         wait_d = '0;
      else if (wait_q != SW'(STARVE_LIMIT))
         wait_d = wait_q + 1'b1;
      if (enq_en && full) ovf_d = 1'b1;
   end

   // Control state register; reset discards all buffered entries.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         wait_q   <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         wait_q   <= wait_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage array, written on accepted pushes; contents are not reset.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= enq_data;
   end

endmodule

// File: tb/tb_arb_req_queue.sv
// Directed bench for arb_req_queue (DEPTH=4, STARVE_LIMIT=15).
module tb_arb_req_queue;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enq_en;
   logic [31:0] enq_data;
   logic        full, almost_full, arb_req, arb_grant, arb_accept;
   logic [31:0] deq_data;
   logic [2:0]  count;
   logic        starve, ovf_err;

   int n_chk = 0;
   int n_fail = 0;

   arb_req_queue #(.DATA_WIDTH(32), .DEPTH(4), .STARVE_LIMIT(15)) dut (
      .clk(clk), .rst_n(rst_n), .enq_en(enq_en), .enq_data(enq_data),
      .full(full), .almost_full(almost_full), .arb_req(arb_req),
      .arb_grant(arb_grant), .arb_accept(arb_accept), .deq_data(deq_data),
      .count(count), .starve(starve), .ovf_err(ovf_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        enq;
      logic [31:0] data;
      logic        grant;
      logic        accept;
      logic        req;
      logic [2:0]  cnt;
      logic        full;
      logic        afull;
      logic        chk_deq;
      logic [31:0] deq;
      logic        starve;
      logic        ovf;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic e, logic [31:0] d, logic g, logic a, logic r,
                               logic [2:0] c, logic f, logic af, logic cd,
                               logic [31:0] q, logic s, logic o);
      vec_t v;
      v.enq = e; v.data = d; v.grant = g; v.accept = a; v.req = r; v.cnt = c;
      v.full = f; v.afull = af; v.chk_deq = cd; v.deq = q; v.starve = s; v.ovf = o;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic e, input logic [31:0] d, input logic g, input logic a);
      enq_en = e; enq_data = d; arb_grant = g; arb_accept = a;
   endtask

   initial begin
      // Table: A,B,C flow; empty grant; overflow; full push+pop; wrap with push+pop at count 2.
      tbl.push_back(mk(1, 32'h11, 0, 0, 1, 1, 0, 0, 1, 32'h11, 0, 0));
      tbl.push_back(mk(1, 32'h22, 0, 0, 1, 2, 0, 0, 1, 32'h11, 0, 0));
      tbl.push_back(mk(1, 32'h33, 0, 0, 1, 3, 0, 1, 1, 32'h11, 0, 0));
      tbl.push_back(mk(0, 32'h0,  1, 1, 1, 2, 0, 0, 1, 32'h22, 0, 0));
      tbl.push_back(mk(0, 32'h0,  1, 1, 1, 1, 0, 0, 1, 32'h33, 0, 0));
      tbl.push_back(mk(0, 32'h0,  1, 1, 0, 0, 0, 0, 0, 32'h0,  0, 0));
      tbl.push_back(mk(0, 32'h0,  1, 1, 0, 0, 0, 0, 0, 32'h0,  0, 0));
      tbl.push_back(mk(1, 32'h100, 0, 0, 1, 1, 0, 0, 1, 32'h100, 0, 0));
      tbl.push_back(mk(1, 32'h101, 0, 0, 1, 2, 0, 0, 1, 32'h100, 0, 0));
      tbl.push_back(mk(1, 32'h102, 0, 0, 1, 3, 0, 1, 1, 32'h100, 0, 0));
      tbl.push_back(mk(1, 32'h103, 0, 0, 1, 4, 1, 1, 1, 32'h100, 0, 0));
      tbl.push_back(mk(1, 32'h104, 0, 0, 1, 4, 1, 1, 1, 32'h100, 0, 1));
      tbl.push_back(mk(1, 32'h105, 1, 1, 1, 3, 0, 1, 1, 32'h101, 0, 1));
      tbl.push_back(mk(0, 32'h0,   1, 1, 1, 2, 0, 0, 1, 32'h102, 0, 1));
      tbl.push_back(mk(1, 32'h106, 1, 1, 1, 2, 0, 0, 1, 32'h103, 0, 1));
      for (int k = 15; k <= 23; k++)
         tbl.push_back(mk(1, 32'h106 + 32'(k - 14), 1, 1, 1, 2, 0, 0, 1,
                          32'h106 + 32'(k - 15), 0, 1));
      tbl.push_back(mk(0, 32'h0, 1, 1, 1, 1, 0, 0, 1, 32'h10F, 0, 1));
      tbl.push_back(mk(0, 32'h0, 1, 1, 0, 0, 0, 0, 0, 32'h0,   0, 1));

      rst_n = 1'b0;
      drive(0, 0, 0, 0);
      #1;
      chk("reset arb_req", 32'(arb_req), 0);
      chk("reset count", 32'(count), 0);
      chk("reset full", 32'(full), 0);
      chk("reset almost_full", 32'(almost_full), 0);
      chk("reset starve", 32'(starve), 0);
      chk("reset ovf_err", 32'(ovf_err), 0);
      step(); step();
      rst_n = 1'b1;
      step();

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].enq, tbl[i].data, tbl[i].grant, tbl[i].accept);
         step();
         chk($sformatf("v%0d arb_req", i), 32'(arb_req), 32'(tbl[i].req));
         chk($sformatf("v%0d count", i), 32'(count), 32'(tbl[i].cnt));
         chk($sformatf("v%0d full", i), 32'(full), 32'(tbl[i].full));
         chk($sformatf("v%0d almost_full", i), 32'(almost_full), 32'(tbl[i].afull));
         chk($sformatf("v%0d starve", i), 32'(starve), 32'(tbl[i].starve));
         chk($sformatf("v%0d ovf_err", i), 32'(ovf_err), 32'(tbl[i].ovf));
         if (tbl[i].chk_deq)
            chk($sformatf("v%0d deq_data", i), deq_data, tbl[i].deq);
      end

      // Starvation: grant without accept never pops; starve after 15 waiting cycles.
      rst_n = 1'b0; #1; rst_n = 1'b1;
      drive(1, 32'hABC, 0, 0);
      step();
      drive(0, 0, 1, 0);
      for (int i = 1; i <= 16; i++) begin
         step();
         chk($sformatf("starve c%0d", i), 32'(starve), (i >= 15) ? 32'd1 : 32'd0);
      end
      chk("starve hold count", 32'(count), 1);
      chk("starve hold arb_req", 32'(arb_req), 1);
      chk("starve hold deq_data", deq_data, 32'hABC);
      drive(0, 0, 1, 1);
      step();
      chk("starve clear", 32'(starve), 0);
      chk("starve pop count", 32'(count), 0);

      // Reset mid-operation with 3 entries, starve and ovf_err set.
      for (int i = 0; i < 5; i++) begin
         drive(1, 32'h200 + 32'(i), 0, 0);
         step();
      end
      drive(0, 0, 1, 1);
      step();
      chk("pre-reset count", 32'(count), 3);
      chk("pre-reset ovf_err", 32'(ovf_err), 1);
      chk("pre-reset deq_data", deq_data, 32'h201);
      drive(0, 0, 0, 0);
      for (int i = 0; i < 16; i++) step();
      chk("pre-reset starve", 32'(starve), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async reset arb_req", 32'(arb_req), 0);
      chk("async reset count", 32'(count), 0);
      chk("async reset starve", 32'(starve), 0);
      chk("async reset ovf_err", 32'(ovf_err), 0);
      step();
      rst_n = 1'b1;
      drive(1, 32'h5A5A, 0, 0);
      #1;
      chk("post-reset no bypass", 32'(arb_req), 0);
      step();
      drive(0, 0, 0, 0);
      chk("post-reset arb_req", 32'(arb_req), 1);
      chk("post-reset count", 32'(count), 1);
      chk("post-reset deq_data", deq_data, 32'h5A5A);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
